// File: rtl/apb2axi_pkg.sv
// Shared types and constants for the APB-to-AXI read-data path.
package apb2axi_pkg;

    localparam int unsigned RDS_TAG_DEPTH = 8;
    localparam int unsigned RDS_APB_W     = 32;
    localparam int unsigned RDS_DATA_W    = 64;

    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Canonical beat layout; FIFO storage packs fields in this same order.
    typedef struct packed {
        logic [RDS_DATA_W-1:0] data;
        logic [1:0]            resp;
        logic                  last;
    } rds_beat_t;

    typedef enum logic {
        RDS_IDLE = 1'b0,
        RDS_OUT  = 1'b1
    } rds_state_t;

endpackage

// File: rtl/apb2axi_tag_fifo.sv
// Single-tag circular beat FIFO with push/pop/flush and occupancy count.
module apb2axi_tag_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 67
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [WIDTH-1:0]       head_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;

    assign head_data = mem[head];
    assign full      = (count == ($clog2(DEPTH)+1)'(DEPTH));

    // Flush outranks a same-cycle pop; the caller never pushes into a flushing tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[tail] <= push_data;
    end

endmodule

// File: rtl/apb2axi_rdata_slicer.sv
// Per-tag AXI read-data buffer returning one APB word per request.
// Optional per-tag high-water mark when APB2AXI_RDS_HWM_EN is defined.
module apb2axi_rdata_slicer
    import apb2axi_pkg::*;
#(
    parameter int unsigned TAG_W     = 4,
    parameter int unsigned N_TAG     = 1 << TAG_W,
    parameter int unsigned TAG_DEPTH = RDS_TAG_DEPTH,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned APB_W     = RDS_APB_W,
    parameter bit          MSW_FIRST = 1'b0
) (
    input  logic                                    pclk,
    input  logic                                    preset,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [TAG_W-1:0]                        in_tag,
    input  logic [DATA_W-1:0]                       in_data,
    input  logic [1:0]                              in_resp,
    input  logic                                    in_last,
    input  logic                                    flush_valid,
    input  logic [TAG_W-1:0]                        flush_tag,
    input  logic                                    req_valid,
    input  logic [TAG_W-1:0]                        req_tag,
    output logic                                    req_ready,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [APB_W-1:0]                        out_data,
    output logic                                    out_last,
    output logic [1:0]                              out_resp,
    output logic                                    out_empty,
    output logic [N_TAG*($clog2(TAG_DEPTH)+1)-1:0]  tag_count
`ifdef APB2AXI_RDS_HWM_EN
    ,
    input  logic                                    hwm_clr,
    output logic [N_TAG*($clog2(TAG_DEPTH)+1)-1:0]  hwm
`endif
);

    localparam int unsigned CNT_W  = $clog2(TAG_DEPTH) + 1;
    localparam int unsigned RATIO  = DATA_W / APB_W;
    localparam int unsigned SIDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int unsigned BEAT_W = DATA_W + 3;

    logic [BEAT_W-1:0] head_data [N_TAG];
    logic [CNT_W-1:0]  cnt       [N_TAG];
    logic [BEAT_W-1:0] hold      [N_TAG];
    logic [SIDX_W-1:0] sidx      [N_TAG];
    logic [N_TAG-1:0]  full;
    logic [N_TAG-1:0]  push;
    logic [N_TAG-1:0]  pop;
    logic [N_TAG-1:0]  flush_vec;

    rds_state_t state;
    rds_state_t state_next;

    logic              req_fire;
    logic [SIDX_W-1:0] cur_idx;
    logic [SIDX_W-1:0] word_sel;
    logic [SIDX_W-1:0] sidx_upd;
    logic              from_head;
    logic              tag_empty;
    logic              final_slice;
    logic              pop_en;
    logic [BEAT_W-1:0] src_beat;
    logic [DATA_W-1:0] src_data;
    logic [APB_W-1:0]  slice_data;

    assign in_ready  = !full[in_tag] && !(flush_valid && (flush_tag == in_tag));
    assign req_ready = (state == RDS_IDLE);
    assign req_fire  = req_valid && req_ready;

    for (genvar g = 0; g < N_TAG; g++) begin : g_tag
        assign push[g]      = in_valid && in_ready && (in_tag == TAG_W'(g));
        assign flush_vec[g] = flush_valid && (flush_tag == TAG_W'(g));
        assign pop[g]       = req_fire && pop_en && (req_tag == TAG_W'(g));

        apb2axi_tag_fifo #(
            .DEPTH (TAG_DEPTH),
            .WIDTH (BEAT_W)
        ) u_fifo (
            .clk       (pclk),
            .rst       (preset),
            .push      (push[g]),
            .push_data ({in_data, in_resp, in_last}),
            .pop       (pop[g]),
            .flush     (flush_vec[g]),
            .head_data (head_data[g]),
            .count     (cnt[g]),
            .full      (full[g])
        );

        assign tag_count[g*CNT_W +: CNT_W] = cnt[g];
    end

    // Slice selection for the requested tag; beats pack as {data, resp, last}.
    always_comb begin
        cur_idx     = sidx[req_tag];
        from_head   = (cur_idx == '0);
        tag_empty   = from_head && (cnt[req_tag] == '0);
        pop_en      = from_head && !tag_empty;
        src_beat    = from_head ? head_data[req_tag] : hold[req_tag];
        src_data    = src_beat[BEAT_W-1:3];
        word_sel    = MSW_FIRST ? (SIDX_W'(RATIO - 1) - cur_idx) : cur_idx;
        slice_data  = src_data[word_sel*APB_W +: APB_W];
        final_slice = (cur_idx == SIDX_W'(RATIO - 1));
        sidx_upd    = final_slice ? '0 : cur_idx + 1'b1;
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) state <= RDS_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            RDS_IDLE: if (req_valid) state_next = RDS_OUT;
            RDS_OUT:  if (out_ready) state_next = RDS_IDLE;
            default:  state_next = RDS_IDLE;
        endcase
    end

    // Flush is applied after the request update so it discards any same-tag slice advance.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            for (int unsigned t = 0; t < N_TAG; t++) begin
                sidx[t] <= '0;
                hold[t] <= '0;
            end
        end else begin
            if (req_fire && !tag_empty && (RATIO > 1)) begin
                if (from_head) hold[req_tag] <= src_beat;
                sidx[req_tag] <= sidx_upd;
            end
            if (flush_valid) begin
                sidx[flush_tag] <= '0;
                hold[flush_tag] <= '0;
            end
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_resp  <= '0;
            out_empty <= 1'b0;
        end else if (req_fire) begin
            out_valid <= 1'b1;
            out_empty <= tag_empty;
            out_data  <= tag_empty ? '0 : slice_data;
            out_last  <= !tag_empty && src_beat[0] && final_slice;
            out_resp  <= tag_empty ? RESP_SLVERR : src_beat[2:1];
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef APB2AXI_RDS_HWM_EN
    logic [CNT_W-1:0] hwm_q [N_TAG];

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            for (int unsigned t = 0; t < N_TAG; t++) hwm_q[t] <= '0;
        end else begin
            for (int unsigned t = 0; t < N_TAG; t++) begin
                if (hwm_clr || flush_vec[t]) hwm_q[t] <= '0;
                else if (cnt[t] > hwm_q[t])  hwm_q[t] <= cnt[t];
            end
        end
    end

    for (genvar h = 0; h < N_TAG; h++) begin : g_hwm
        assign hwm[h*CNT_W +: CNT_W] = hwm_q[h];
    end
`endif

endmodule

// File: tb/tb_apb2axi_rdata_slicer.sv
// Bench for apb2axi_rdata_slicer: LSW-first and MSW-first instances against a word-queue model.
module tb_apb2axi_rdata_slicer;

    logic        pclk = 1'b0;
    logic        preset = 1'b1;
    logic        in_valid = 1'b0;
    logic [3:0]  in_tag = '0;
    logic [63:0] in_data = '0;
    logic [1:0]  in_resp = '0;
    logic        in_last = 1'b0;
    logic        flush_valid = 1'b0;
    logic [3:0]  flush_tag = '0;
    logic        req_valid = 1'b0;
    logic [3:0]  req_tag = '0;
    logic        out_ready = 1'b0;

    logic        in_ready, req_ready, out_valid, out_last, out_empty;
    logic [31:0] out_data;
    logic [1:0]  out_resp;
    logic [63:0] tag_count;
    logic        in_ready_m, req_ready_m, out_valid_m, out_last_m, out_empty_m;
    logic [31:0] out_data_m;
    logic [1:0]  out_resp_m;
    logic [63:0] tag_count_m;
`ifdef APB2AXI_RDS_HWM_EN
    logic        hwm_clr = 1'b0;
    logic [63:0] hwm, hwm_m;
`endif

    int errors = 0;
    int checks = 0;

    // Model: each tag holds its pending APB words as {last, resp, data}, in delivery order.
    logic [34:0] ql [16][$];
    logic [34:0] qm [16][$];

    always #5 pclk = ~pclk;

    apb2axi_rdata_slicer #(.TAG_W(4), .TAG_DEPTH(8), .DATA_W(64), .APB_W(32), .MSW_FIRST(1'b0)) dut (
        .pclk(pclk), .preset(preset), .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag),
        .in_data(in_data), .in_resp(in_resp), .in_last(in_last), .flush_valid(flush_valid),
        .flush_tag(flush_tag), .req_valid(req_valid), .req_tag(req_tag), .req_ready(req_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .out_resp(out_resp), .out_empty(out_empty), .tag_count(tag_count)
`ifdef APB2AXI_RDS_HWM_EN
        , .hwm_clr(hwm_clr), .hwm(hwm)
`endif
    );

    apb2axi_rdata_slicer #(.TAG_W(4), .TAG_DEPTH(8), .DATA_W(64), .APB_W(32), .MSW_FIRST(1'b1)) dut_msw (
        .pclk(pclk), .preset(preset), .in_valid(in_valid), .in_ready(in_ready_m), .in_tag(in_tag),
        .in_data(in_data), .in_resp(in_resp), .in_last(in_last), .flush_valid(flush_valid),
        .flush_tag(flush_tag), .req_valid(req_valid), .req_tag(req_tag), .req_ready(req_ready_m),
        .out_valid(out_valid_m), .out_ready(out_ready), .out_data(out_data_m), .out_last(out_last_m),
        .out_resp(out_resp_m), .out_empty(out_empty_m), .tag_count(tag_count_m)
`ifdef APB2AXI_RDS_HWM_EN
        , .hwm_clr(hwm_clr), .hwm(hwm_m)
`endif
    );

    // Beats still in a tag FIFO = whole beats among the pending words (a started beat is already out).
    function automatic int mcnt(input int t);
        return ql[t].size() / 2;
    endfunction

    function automatic logic [63:0] mcounts();
        logic [63:0] v;
        for (int t = 0; t < 16; t++) v[t*4 +: 4] = 4'(mcnt(t));
        return v;
    endfunction

    // One clock of stimulus (push / request / flush), then the full response handshake if requested.
    task automatic cycle(input bit pe, input int pt, input logic [63:0] pd, input logic [1:0] pr,
                         input bit pl, input bit re, input int rt, input bit fe, input int ft,
                         input string nm);
        bit          exp_rdy;
        bit          emp;
        logic [34:0] wl, wm;
        logic [63:0] exp_tc;
        in_valid = pe; in_tag = 4'(pt); in_data = pd; in_resp = pr; in_last = pl;
        req_valid = re; req_tag = 4'(rt); flush_valid = fe; flush_tag = 4'(ft);
        #1;
        exp_rdy = (mcnt(pt) < 8) && !(fe && ft == pt);
        checks++;
        if (in_ready !== exp_rdy || in_ready_m !== exp_rdy) begin
            errors++;
            $display("FAIL %s in_ready: got %b/%b expected %b", nm, in_ready, in_ready_m, exp_rdy);
        end
        checks++;
        if (req_ready !== 1'b1 || req_ready_m !== 1'b1) begin
            errors++;
            $display("FAIL %s req_ready_idle: got %b/%b expected 1", nm, req_ready, req_ready_m);
        end
        emp = 1'b1;
        wl = {1'b0, 2'b10, 32'h0};
        wm = {1'b0, 2'b10, 32'h0};
        if (re && ql[rt].size() != 0) begin
            emp = 1'b0;
            wl = ql[rt].pop_front();
            wm = qm[rt].pop_front();
        end
        if (pe && exp_rdy) begin
            ql[pt].push_back({1'b0, pr, pd[31:0]});
            ql[pt].push_back({pl, pr, pd[63:32]});
            qm[pt].push_back({1'b0, pr, pd[63:32]});
            qm[pt].push_back({pl, pr, pd[31:0]});
        end
        if (fe) begin
            ql[ft].delete();
            qm[ft].delete();
        end
        @(posedge pclk); #1;
        in_valid = 1'b0; req_valid = 1'b0; flush_valid = 1'b0;
        exp_tc = mcounts();
        checks++;
        if (tag_count !== exp_tc || tag_count_m !== exp_tc) begin
            errors++;
            $display("FAIL %s tag_count: got %h/%h expected %h", nm, tag_count, tag_count_m, exp_tc);
        end
        if (re) begin
            checks++;
            if (out_valid !== 1'b1 || out_valid_m !== 1'b1 || out_empty !== emp || out_empty_m !== emp) begin
                errors++;
                $display("FAIL %s out_valid/empty: got %b%b/%b%b expected 1%b", nm,
                         out_valid, out_empty, out_valid_m, out_empty_m, emp);
            end
            checks++;
            if ({out_last, out_resp, out_data} !== wl) begin
                errors++;
                $display("FAIL %s word_lsw: got %h expected %h", nm, {out_last, out_resp, out_data}, wl);
            end
            checks++;
            if ({out_last_m, out_resp_m, out_data_m} !== wm) begin
                errors++;
                $display("FAIL %s word_msw: got %h expected %h", nm, {out_last_m, out_resp_m, out_data_m}, wm);
            end
            out_ready = 1'b1;
            @(posedge pclk); #1;
            out_ready = 1'b0;
            checks++;
            if (out_valid !== 1'b0 || out_valid_m !== 1'b0) begin
                errors++;
                $display("FAIL %s out_valid_clear: got %b/%b expected 0", nm, out_valid, out_valid_m);
            end
        end
    endtask

    task automatic clear_model();
        for (int t = 0; t < 16; t++) begin
            ql[t].delete();
            qm[t].delete();
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({out_valid, out_last, out_empty, out_data, out_resp} !== '0 || tag_count !== '0 ||
            req_ready !== 1'b1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: got v%b l%b e%b d%h r%b tc%h rr%b ir%b expected zeros rr1 ir1",
                     out_valid, out_last, out_empty, out_data, out_resp, tag_count, req_ready, in_ready);
        end
        @(negedge pclk);
        preset = 1'b0;
        @(posedge pclk); #1;
    endtask

    task automatic test_basic();
        cycle(1, 3, 64'h1111_2222_3333_4444, 2'b00, 0, 0, 0, 0, 15, "push_b0");
        cycle(1, 3, 64'h5555_6666_7777_8888, 2'b00, 1, 0, 0, 0, 15, "push_b1");
        cycle(0, 0, '0, 2'b00, 0, 1, 3, 0, 15, "req1");
        checks++;
        if (out_data !== 32'h3333_4444 || out_data_m !== 32'h1111_2222) begin
            errors++;
            $display("FAIL first_word_order: got %h/%h expected 33334444/11112222", out_data, out_data_m);
        end
        for (int i = 0; i < 3; i++) cycle(0, 0, '0, 2'b00, 0, 1, 3, 0, 15, "req_rest");
    endtask

    task automatic test_full();
        for (int i = 0; i < 8; i++)
            cycle(1, 1, {$urandom, $urandom}, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 0, 0, 0, 15, "fill");
        cycle(1, 1, 64'hDEAD_BEEF_0000_0001, 2'b00, 0, 0, 0, 0, 15, "push_full");
        cycle(1, 2, 64'hAAAA_BBBB_CCCC_DDDD, 2'b01, 1, 0, 0, 0, 15, "push_other");
        cycle(0, 0, '0, 2'b00, 0, 1, 1, 0, 15, "pop_one");
        cycle(1, 1, 64'h9999_8888_7777_6666, 2'b11, 1, 0, 0, 0, 15, "push_wrap");
        for (int i = 0; i < 18; i++) cycle(0, 0, '0, 2'b00, 0, 1, 1, 0, 15, "drain1");
        for (int i = 0; i < 2; i++) cycle(0, 0, '0, 2'b00, 0, 1, 2, 0, 15, "drain2");
    endtask

    task automatic test_empty();
        cycle(0, 0, '0, 2'b00, 0, 1, 5, 0, 15, "empty_req");
        checks++;
        if (out_data !== 32'h0 || out_resp !== 2'b10 || out_empty !== 1'b1 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL empty_fields: got d%h r%b e%b l%b expected d0 r10 e1 l0", out_data, out_resp, out_empty, out_last);
        end
        cycle(1, 5, 64'h0123_4567_89AB_CDEF, 2'b00, 1, 0, 0, 0, 15, "empty_then_push");
        cycle(0, 0, '0, 2'b00, 0, 1, 5, 0, 15, "empty_then_req");
        cycle(0, 0, '0, 2'b00, 0, 1, 5, 0, 15, "empty_then_req2");
    endtask

    task automatic test_stall_reset();
        logic [34:0] w;
        cycle(1, 7, 64'hCAFE_F00D_1234_5678, 2'b01, 0, 0, 0, 0, 15, "stall_push0");
        cycle(1, 7, 64'h0BAD_0BAD_5A5A_A5A5, 2'b00, 1, 0, 0, 0, 15, "stall_push1");
        w = ql[7].pop_front();
        void'(qm[7].pop_front());
        req_valid = 1'b1; req_tag = 4'd7;
        @(posedge pclk); #1;
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || {out_last, out_resp, out_data} !== w || req_ready !== 1'b0 || out_empty !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold: got v%b w%h rr%b e%b expected v1 w%h rr0 e0",
                         out_valid, {out_last, out_resp, out_data}, req_ready, out_empty, w);
            end
            @(posedge pclk); #1;
        end
        #2 preset = 1'b1;
        #1;
        checks++;
        if ({out_valid, out_last, out_empty, out_data, out_resp} !== '0 || tag_count !== '0 ||
            out_valid_m !== 1'b0 || tag_count_m !== '0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: got v%b l%b e%b d%h r%b tc%h rr%b expected zeros rr1",
                     out_valid, out_last, out_empty, out_data, out_resp, tag_count, req_ready);
        end
        clear_model();
        @(negedge pclk);
        preset = 1'b0;
        @(posedge pclk); #1;
    endtask

    task automatic test_flush();
        cycle(1, 0, 64'h0000_0001_0000_0002, 2'b00, 0, 0, 0, 0, 15, "fl_push0");
        cycle(1, 0, 64'h0000_0003_0000_0004, 2'b00, 0, 0, 0, 0, 15, "fl_push1");
        cycle(0, 0, '0, 2'b00, 0, 1, 0, 0, 15, "fl_req");
        cycle(1, 0, 64'h0000_0005_0000_0006, 2'b00, 0, 0, 0, 0, 15, "fl_push2");
        cycle(1, 0, 64'h0000_0007_0000_0008, 2'b00, 1, 0, 0, 0, 15, "fl_push3");
        checks++;
        if (tag_count[3:0] !== 4'd3) begin
            errors++;
            $display("FAIL flush_pre_count: got %0d expected 3", tag_count[3:0]);
        end
`ifdef APB2AXI_RDS_HWM_EN
        @(posedge pclk); #1;
        checks++;
        if (hwm[3:0] !== 4'd3 || hwm_m[3:0] !== 4'd3) begin
            errors++;
            $display("FAIL hwm_pre: got %0d/%0d expected 3", hwm[3:0], hwm_m[3:0]);
        end
`endif
        cycle(1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 1, 0, 0, 1, 0, "flush_push");
`ifdef APB2AXI_RDS_HWM_EN
        checks++;
        if (hwm[3:0] !== 4'd0 || hwm_m[3:0] !== 4'd0) begin
            errors++;
            $display("FAIL hwm_post: got %0d/%0d expected 0", hwm[3:0], hwm_m[3:0]);
        end
`endif
        cycle(0, 0, '0, 2'b00, 0, 1, 0, 0, 15, "flush_req_empty");
        cycle(1, 9, 64'h1234_0000_5678_0000, 2'b01, 0, 0, 0, 0, 15, "fr_push0");
        cycle(1, 9, 64'h4321_0000_8765_0000, 2'b00, 1, 0, 0, 0, 15, "fr_push1");
        cycle(0, 0, '0, 2'b00, 0, 1, 9, 1, 9, "req_with_flush");
        cycle(0, 0, '0, 2'b00, 0, 1, 9, 0, 15, "req_after_flush");
    endtask

    task automatic test_back_to_back();
        cycle(1, 4, 64'h4444_0000_4444_0001, 2'b00, 1, 0, 0, 0, 15, "b2b_push");
        cycle(1, 4, 64'h4444_0002_4444_0003, 2'b10, 0, 1, 4, 0, 15, "b2b_push_pop");
        cycle(0, 0, '0, 2'b00, 0, 1, 6, 0, 15, "b2b_empty_other");
        for (int i = 0; i < 3; i++) cycle(0, 0, '0, 2'b00, 0, 1, 4, 0, 15, "b2b_drain");
        cycle(1, 6, 64'h6666_1111_6666_2222, 2'b00, 1, 1, 6, 0, 15, "push_into_empty_req");
    endtask

    task automatic test_random();
        bit pe, re, fe;
        int pt, rt, ft;
        for (int i = 0; i < 120; i++) begin
            pe = ($urandom_range(0, 3) != 0);
            re = ($urandom_range(0, 2) == 0);
            fe = ($urandom_range(0, 11) == 0);
            pt = 8 + $urandom_range(0, 3);
            rt = 8 + $urandom_range(0, 3);
            ft = 8 + $urandom_range(0, 3);
            cycle(pe, pt, {$urandom, $urandom}, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  re, rt, fe, ft, "random");
        end
    endtask

    initial begin
        clear_model();
        test_reset();
        test_basic();
        test_full();
        test_empty();
        test_stall_reset();
        test_flush();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apb2axi_rdata_slicer.md
Name: apb2axi_rdata_slicer

Overview:
- Per-tag read-data buffer between the AXI read-data FIFO (RDF) and the APB data-drain path.
- Stores AXI beats in independent circular FIFOs, one per tag, and returns them one APB word per request through a valid/ready output.
- Generalised successor block: parametrised tag count, depth, AXI/APB width ratio and slice order, plus a per-tag flush.
- Produces correct last-word marking and a well-defined empty-request response.

Parameters:
- TAG_W, 4: tag width.
- N_TAG, 1<<TAG_W: number of per-tag FIFOs.
- TAG_DEPTH, 8: beats per tag FIFO. Must be a power of 2, and at least 2.
- DATA_W, 64: AXI beat width.
- APB_W, 32: APB word width. DATA_W must be an integer multiple of APB_W.
- MSW_FIRST, 0: slice order within a beat. 0 = low word first; 1 = high word first.

Ports:
- pclk  in  1  clock
- preset  in  1  asynchronous active-high reset
- in_valid  in  1  RDF beat valid
- in_ready  out  1  beat accepted (combinational)
- in_tag  in  TAG_W  beat tag
- in_data  in  DATA_W  beat data
- in_resp  in  2  AXI RRESP
- in_last  in  1  AXI RLAST
- flush_valid  in  1  single-cycle flush strobe
- flush_tag  in  TAG_W  tag to flush
- req_valid  in  1  word request
- req_tag  in  TAG_W  requested tag
- req_ready  out  1  request accepted
- out_valid  out  1  word valid
- out_ready  in  1  word consumed
- out_data  out  APB_W  word
- out_last  out  1  final word of burst
- out_resp  out  2  RRESP of source beat
- out_empty  out  1  request hit empty tag
- tag_count  out  N_TAG*($clog2(TAG_DEPTH)+1)  per-tag occupancy, packed

Behaviour:
- Reset: asynchronous on preset high, cleared in the same instant.
  - All head/tail/count/slice_idx = 0, all holding registers = 0.
  - state = IDLE; out_valid, out_last, out_empty = 0; out_data = 0; out_resp = 0.
- Constant RATIO = DATA_W/APB_W.
- Ingest:
  - in_ready = (count[in_tag] < TAG_DEPTH) && !(flush_valid && flush_tag == in_tag).
  - On in_valid && in_ready: write {data,resp,last} at tail; tail += 1 modulo TAG_DEPTH (natural wrap); count += 1.
  - Full tag: in_ready = 0; other tags are unaffected.
- FSM has two states, IDLE and OUT. req_ready = (state == IDLE).
- IDLE, on req_valid && req_ready: latch tag T, go to OUT. out_valid rises the next cycle (1-cycle latency).
  - slice_idx[T] == 0 and count[T] > 0:
    - Read the head beat and emit its first slice: slice 0 if MSW_FIRST = 0, slice RATIO-1 if MSW_FIRST = 1.
    - If RATIO > 1: pop the beat (head += 1, count -= 1), copy it into hold[T], set slice_idx[T] = 1.
    - If RATIO == 1: pop only.
  - slice_idx[T] > 0: emit the next slice from hold[T]; slice_idx[T] += 1, wrapping to 0 when it reaches RATIO.
  - slice_idx[T] == 0 and count[T] == 0: out_data = 0, out_empty = 1, out_last = 0, out_resp = 2'b10. No state change for T.
- out_last = beat.last && (slice emitted is the beat's final slice).
- out_resp = resp of the source beat.
- OUT: out_data, out_last, out_resp and out_empty are held stable while out_valid && !out_ready. On out_ready, clear out_valid and go to IDLE. At most one outstanding request.
- Same tag, same cycle:
  - Push and pop together: count unchanged, both pointers advance.
  - Push and flush together: push refused (in_ready = 0), flush wins.
- Flush of tag F: head = tail = count = slice_idx = 0 and hold cleared, next cycle.
  - A word already latched in OUT for F is still delivered unchanged.
  - A request for F accepted in the same cycle as the flush sees the pre-flush state. The flush then applies, and the pop/slice update for F is discarded.
- tag_count: registered count values, no bypass.

Optional Feature:
- Macro APB2AXI_RDS_HWM_EN.
- Defined:
  - Adds output hwm, N_TAG*($clog2(TAG_DEPTH)+1) bits wide.
  - Per-tag high-water mark of count: updated each cycle to max(hwm, count), cleared by reset and by a flush of that tag.
  - Adds input hwm_clr (1 bit), which clears all marks.
- Undefined: neither port exists and there is no extra logic.

Decomposition:
- apb2axi_pkg gets:
  - rds_beat_t {data, resp, last}.
  - RESP_SLVERR constant.
  - Default parameter constants RDS_TAG_DEPTH and RDS_APB_W.
- One sub-module, apb2axi_tag_fifo: a single-tag circular FIFO with push/pop/flush and count. Instantiate it N_TAG times in a generate loop.
- Slicing FSM and output register live in the top module.

Test Plan:
1. DATA_W=64, APB_W=32.
   - Push tag 3 beats 0x1111_2222_3333_4444 (last=0) and 0x5555_6666_7777_8888 (last=1).
   - Issue 4 requests → 0x33334444, 0x11112222, 0x77778888, 0x55556666.
   - out_last only on the 4th word; count[3] goes 2→1→1→0→0.
2. MSW_FIRST=1, same data → first word 0x11112222, then 0x33334444.
3. Fill tag 1 with 8 beats → in_ready=0 for tag 1 while tag 2 still accepts. One pop → in_ready=1; push a 9th beat → tail wraps to 0 and data reads back in order.
4. Request tag 5 when empty → 1 cycle later out_valid=1, out_empty=1, out_data=0, out_resp=2'b10; tag 5 state unchanged.
5. Hold out_ready=0 for 5 cycles → outputs stable and req_ready=0 throughout. Assert preset mid-burst → all outputs 0 immediately and counts 0.
6. Flush tag 0 with slice_idx=1 and count=3, with a push to tag 0 in the same cycle → push refused; count 0; next request returns out_empty=1.
   - With APB2AXI_RDS_HWM_EN defined, hwm[0] reads 3 before the flush and 0 after.
